// File: rtl/buffer_set_reader.sv
// buffer_set_reader: pops whole sets from the ring buffer and streams them as LANES-word beats
//   clk, rst          clock, async active-high reset
//   enable            permits popping new sets; an in-flight set always completes
//   flush             synchronous abort, drops the held set
//   buf_empty         ring buffer empty flag
//   buf_dout          head set of the buffer (combinational)
//   buf_ren           pop strobe, high on the capture edge only
//   m_valid/m_ready   beat handshake
//   m_data, m_last    beat payload and last-beat marker
//   busy              streaming a set
//   set_count         sets fully streamed since reset
module buffer_set_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_OF_SET = 128,
    parameter int LANES       = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    enable,
    input  logic                                    flush,
    input  logic                                    buf_empty,
    input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]  buf_dout,
    output logic                                    buf_ren,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [LANES-1:0][DATA_WIDTH-1:0]        m_data,
    output logic                                    m_last,
    output logic                                    busy,
    output logic [15:0]                             set_count
);
    localparam int BEATS = DATA_OF_SET / LANES;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state, state_nx;
    logic [BW-1:0] beat, beat_nx;
    // Same bit layout as buf_dout, regrouped so a beat is a single index.
    logic [BEATS-1:0][LANES-1:0][DATA_WIDTH-1:0] set_reg;
    logic last, hs, pop;

    always_comb begin
        last     = beat == BW'(BEATS - 1);
        hs       = state == STREAM && m_ready;
        // Capture from IDLE, or gaplessly on the last handshake of a set.
        pop      = !rst && !flush && enable && !buf_empty && (state == IDLE || (hs && last));
        state_nx = state;
        beat_nx  = beat;
        if (flush) begin
            state_nx = IDLE;
            beat_nx  = '0;
        end else if (pop) begin
            state_nx = STREAM;
            beat_nx  = '0;
        end else if (hs && last) begin
            state_nx = IDLE;
            beat_nx  = '0;
        end else if (hs) begin
            beat_nx  = beat + 1'b1;
        end
    end

    assign buf_ren = pop;
    assign m_valid = state == STREAM;
    assign busy    = m_valid;
    assign m_last  = m_valid && last;
    assign m_data  = set_reg[beat];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            set_reg   <= '0;
            set_count <= '0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
            if (pop)
                set_reg <= buf_dout;
            if (!flush && hs && last)
                set_count <= set_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_buffer_set_reader.sv
// tb_buffer_set_reader: directed check of buffer_set_reader with 8-word sets, 4 lanes
module tb_buffer_set_reader;
    localparam int DW = 32;
    localparam int DS = 8;
    localparam int LN = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enable = 1'b0;
    logic                    flush = 1'b0;
    logic                    buf_empty = 1'b1;
    logic [DS-1:0][DW-1:0]   buf_dout = '0;
    logic                    buf_ren;
    logic                    m_valid;
    logic                    m_ready = 1'b1;
    logic [LN-1:0][DW-1:0]   m_data;
    logic                    m_last;
    logic                    busy;
    logic [15:0]             set_count;

    int vecs = 0;
    int errs = 0;

    buffer_set_reader #(.DATA_WIDTH(DW), .DATA_OF_SET(DS), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .buf_empty(buf_empty), .buf_dout(buf_dout), .buf_ren(buf_ren),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .set_count(set_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base);
        for (int i = 0; i < DS; i++)
            buf_dout[i] = 32'(base + i + 1);
    endtask

    function automatic logic [127:0] beat_val(input int base, input int b);
        logic [127:0] r;
        for (int j = 0; j < LN; j++)
            r[j*32 +: 32] = 32'(base + b * LN + j + 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #3;
        chk("rst_ren",   128'(buf_ren), 128'(0));
        chk("rst_valid", 128'(m_valid), 128'(0));
        chk("rst_last",  128'(m_last), 128'(0));
        chk("rst_busy",  128'(busy), 128'(0));
        chk("rst_data",  128'(m_data), 128'(0));
        chk("rst_count", 128'(set_count), 128'(0));
        tick();
        tick();
        rst = 1'b0;

        // single set
        load(0);
        enable = 1'b1;
        buf_empty = 1'b0;
        #1 chk("s1_pop", 128'(buf_ren), 128'(1));
        tick();
        buf_empty = 1'b1;
        #1 chk("s1_v0", 128'(m_valid), 128'(1));
        chk("s1_d0",  128'(m_data), beat_val(0, 0));
        chk("s1_l0",  128'(m_last), 128'(0));
        chk("s1_r0",  128'(buf_ren), 128'(0));
        tick();
        chk("s1_d1",  128'(m_data), beat_val(0, 1));
        chk("s1_l1",  128'(m_last), 128'(1));
        chk("s1_r1",  128'(buf_ren), 128'(0));
        tick();
        chk("s1_idle", 128'(m_valid), 128'(0));
        chk("s1_busy", 128'(busy), 128'(0));
        chk("s1_cnt",  128'(set_count), 128'(1));

        // three sets back to back
        load(16);
        buf_empty = 1'b0;
        #1 chk("b2b_pop0", 128'(buf_ren), 128'(1));
        tick();
        load(32);
        for (int s = 0; s < 3; s++) begin
            #1 chk("b2b_v0", 128'(m_valid), 128'(1));
            chk("b2b_d0", 128'(m_data), beat_val(16 + 16 * s, 0));
            chk("b2b_r0", 128'(buf_ren), 128'(0));
            tick();
            chk("b2b_v1", 128'(m_valid), 128'(1));
            chk("b2b_d1", 128'(m_data), beat_val(16 + 16 * s, 1));
            chk("b2b_l1", 128'(m_last), 128'(1));
            chk("b2b_r1", 128'(buf_ren), 128'(s < 2));
            tick();
            if (s == 0) load(48);
            else if (s == 1) buf_empty = 1'b1;
        end
        #1 chk("b2b_idle", 128'(m_valid), 128'(0));
        chk("b2b_cnt", 128'(set_count), 128'(4));

        // backpressure
        load(64);
        buf_empty = 1'b0;
        m_ready = 1'b0;
        #1 chk("bp_pop", 128'(buf_ren), 128'(1));
        tick();
        buf_empty = 1'b1;
        #1 chk("bp_d0a", 128'(m_data), beat_val(64, 0));
        chk("bp_r0", 128'(buf_ren), 128'(0));
        tick();
        chk("bp_d0b", 128'(m_data), beat_val(64, 0));
        chk("bp_l0b", 128'(m_last), 128'(0));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        #1 chk("bp_d1a", 128'(m_data), beat_val(64, 1));
        chk("bp_l1a", 128'(m_last), 128'(1));
        tick();
        chk("bp_d1b", 128'(m_data), beat_val(64, 1));
        chk("bp_l1b", 128'(m_last), 128'(1));
        chk("bp_v1b", 128'(m_valid), 128'(1));
        chk("bp_r1b", 128'(buf_ren), 128'(0));
        m_ready = 1'b1;
        tick();
        chk("bp_idle", 128'(m_valid), 128'(0));
        chk("bp_cnt", 128'(set_count), 128'(5));

        // empty buffer, then enable low with data present
        #1 chk("em_ren", 128'(buf_ren), 128'(0));
        tick();
        chk("em_valid", 128'(m_valid), 128'(0));
        load(80);
        enable = 1'b0;
        buf_empty = 1'b0;
        #1 chk("en_ren", 128'(buf_ren), 128'(0));
        tick();
        chk("en_valid", 128'(m_valid), 128'(0));
        enable = 1'b1;
        #1 chk("en_pop", 128'(buf_ren), 128'(1));
        tick();
        load(96);
        enable = 1'b0;
        #1 chk("en_d0", 128'(m_data), beat_val(80, 0));
        chk("en_r0", 128'(buf_ren), 128'(0));
        tick();
        chk("en_l1", 128'(m_last), 128'(1));
        chk("en_r1", 128'(buf_ren), 128'(0));
        tick();
        chk("en_idle", 128'(m_valid), 128'(0));
        chk("en_ridle", 128'(buf_ren), 128'(0));
        chk("en_cnt", 128'(set_count), 128'(6));

        // flush on the last beat
        enable = 1'b1;
        #1 chk("fl_pop", 128'(buf_ren), 128'(1));
        tick();
        load(112);
        #1 chk("fl_d0", 128'(m_data), beat_val(96, 0));
        tick();
        flush = 1'b1;
        #1 chk("fl_ren", 128'(buf_ren), 128'(0));
        tick();
        flush = 1'b0;
        #1 chk("fl_idle", 128'(m_valid), 128'(0));
        chk("fl_cnt", 128'(set_count), 128'(6));
        chk("fl_repop", 128'(buf_ren), 128'(1));
        tick();
        buf_empty = 1'b1;
        #1 chk("fl_fresh", 128'(m_data), beat_val(112, 0));
        chk("fl_beat0", 128'(m_last), 128'(0));
        tick();
        tick();
        chk("fl_cnt2", 128'(set_count), 128'(7));

        // async reset mid-set
        load(128);
        buf_empty = 1'b0;
        tick();
        #1 chk("ar_d0", 128'(m_data), beat_val(128, 0));
        #2 rst = 1'b1;
        #1 chk("ar_valid", 128'(m_valid), 128'(0));
        chk("ar_data", 128'(m_data), 128'(0));
        chk("ar_busy", 128'(busy), 128'(0));
        chk("ar_ren", 128'(buf_ren), 128'(0));
        chk("ar_cnt", 128'(set_count), 128'(0));
        tick();
        rst = 1'b0;
        #1 chk("ar_pop", 128'(buf_ren), 128'(1));
        tick();
        chk("ar_v", 128'(m_valid), 128'(1));
        chk("ar_d", 128'(m_data), beat_val(128, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
